rng_state_arbiter: RTL

RNG_STATE_ARBITER -- requirements
Module: rng_state_arbiter

---
 rtl/rng_state_pkg.sv | 20 ++
 rtl/rng_state_arbiter_if.sv | 27 ++
 rtl/rng_state_mem.sv | 31 +++
 rtl/rng_state_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/rng_state_pkg.sv
// Shared types and constants for the RNG state arbiter.
// ZERO state exists only when RNG_STATE_ARB_ZEROIZE_EN is defined.
package rng_state_pkg;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
    localparam int OFS_W   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
`ifdef RNG_STATE_ARB_ZEROIZE_EN
        RESP = 2'd2,
        ZERO = 2'd3
`else
        RESP = 2'd2
`endif
    } state_t;

endpackage

// File: rtl/rng_state_arbiter_if.sv
// Request/response bundle between requesters (master) and the arbiter (slave).
interface rng_state_arbiter_if
    import rng_state_pkg::*;
#(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ-1:0]       req_we;
    logic [OFS_W*NUM_REQ-1:0] req_offset;
    logic [LEN_W*NUM_REQ-1:0] req_len;
    logic [64*NUM_REQ-1:0]    req_wdata;
    logic                     rsp_valid;
    logic [2:0]               rsp_id;
    logic [63:0]              rsp_rdata;
    logic                     rsp_err;

    modport master (
        output req_valid, req_we, req_offset, req_len, req_wdata,
        input  req_ready, rsp_valid, rsp_id, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_offset, req_len, req_wdata,
        output req_ready, rsp_valid, rsp_id, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/rng_state_mem.sv
// Single-port byte store: synchronous write, registered read (1-cycle latency).
module rng_state_mem #(
    parameter int NUM_BYTES = 32,
    parameter int ADDR_W    = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);
    logic [7:0] mem_q [NUM_BYTES];
    logic [7:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[addr];
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/rng_state_arbiter.sv
// Round-robin arbiter granting byte-wise access to a shared RNG state store.
// Optional RNG_STATE_ARB_ZEROIZE_EN adds the zeroize port and the ZERO clearing state.
//
// state | meaning
// IDLE  | pick next requester round-robin, capture request
// XFER  | one byte per cycle, len cycles
// RESP  | one-cycle response strobe
// ZERO  | clear one byte per cycle over the whole store
module rng_state_arbiter
    import rng_state_pkg::*;
#(
    parameter int NUM_BYTES = 32,
    parameter int NUM_REQ   = 4
) (
    input  logic clk,
    input  logic rst,
`ifdef RNG_STATE_ARB_ZEROIZE_EN
    input  logic zeroize,
`endif
    rng_state_arbiter_if.slave bus
);
    localparam int GNT_W  = $clog2(NUM_REQ);
    localparam int ADDR_W = $clog2(NUM_BYTES);
    localparam int END_W  = OFS_W + 1;

    state_t             state_q, state_d;
    logic [GNT_W-1:0]   last_grant_q, last_grant_d;
    logic [GNT_W-1:0]   id_q, id_d;
    logic               we_q, we_d;
    logic               err_q, err_d;
    logic [OFS_W-1:0]   ofs_q, ofs_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   idx_q, idx_d;
    logic [63:0]        wdata_q, wdata_d;
    logic [63:0]        acc_q, acc_d;
    logic [2:0]         rsp_id_q, rsp_id_d;
    logic [63:0]        rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;
`ifdef RNG_STATE_ARB_ZEROIZE_EN
    logic [ADDR_W-1:0]  zcnt_q, zcnt_d;
    logic               post_rst_q, post_rst_d;
`endif

    logic               gnt_found;
    logic [GNT_W-1:0]   gnt_idx, cand;
    logic               sel_we, sel_err;
    logic [OFS_W-1:0]   sel_ofs;
    logic [LEN_W-1:0]   sel_len;
    logic [63:0]        sel_wdata;
    logic [END_W-1:0]   sel_end;
    logic [NUM_REQ-1:0] ready_c;
    logic [63:0]        rsp_data_c;
    logic [2:0]         idx_b, prev_b, last_b;
    logic               mem_we, mem_re;
    logic [ADDR_W-1:0]  mem_addr;
    logic [7:0]         mem_wdata, mem_rdata;

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = GNT_W'((int'(last_grant_q) + 1 + i) % NUM_REQ);
            if (!gnt_found && bus.req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // End address is formed one bit wider so offset+len cannot wrap.
    always_comb begin
        sel_we    = bus.req_we[gnt_idx];
        sel_ofs   = bus.req_offset[int'(gnt_idx)*OFS_W +: OFS_W];
        sel_len   = bus.req_len[int'(gnt_idx)*LEN_W +: LEN_W];
        sel_wdata = bus.req_wdata[int'(gnt_idx)*64 +: 64];
        sel_end   = {1'b0, sel_ofs} + END_W'(sel_len);
        sel_err   = (sel_len == '0) || (sel_len > LEN_W'(MAX_LEN)) ||
                    (sel_end > END_W'(NUM_BYTES));
    end

    assign idx_b  = idx_q[2:0];
    assign prev_b = idx_b - 3'd1;
    assign last_b = 3'(len_q - 1'b1);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        we_d         = we_q;
        err_d        = err_q;
        ofs_d        = ofs_q;
        len_d        = len_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        acc_d        = acc_q;
        rsp_id_d     = rsp_id_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;
        ready_c      = '0;
        mem_we       = 1'b0;
        mem_re       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
`ifdef RNG_STATE_ARB_ZEROIZE_EN
        zcnt_d       = zcnt_q;
        post_rst_d   = post_rst_q;
`endif
        // Final read byte lands from the store during RESP itself.
        rsp_data_c = acc_q;
        if (!we_q && !err_q) begin
            rsp_data_c[8*last_b +: 8] = mem_rdata;
        end

        case (state_q)
            IDLE: begin
`ifdef RNG_STATE_ARB_ZEROIZE_EN
                if (zeroize || post_rst_q) begin
                    state_d    = ZERO;
                    zcnt_d     = ADDR_W'(NUM_BYTES - 1);
                    post_rst_d = 1'b0;
                end else
`endif
                if (gnt_found) begin
                    ready_c[gnt_idx] = 1'b1;
                    last_grant_d     = gnt_idx;
                    id_d             = gnt_idx;
                    we_d             = sel_we;
                    ofs_d            = sel_ofs;
                    len_d            = sel_len;
                    wdata_d          = sel_wdata;
                    err_d            = sel_err;
                    idx_d            = '0;
                    acc_d            = '0;
                    state_d          = sel_err ? RESP : XFER;
                end
            end
            XFER: begin
                mem_addr  = ADDR_W'({1'b0, ofs_q} + END_W'(idx_q));
                mem_we    = we_q;
                mem_re    = !we_q;
                mem_wdata = wdata_q[8*idx_b +: 8];
                if (!we_q && idx_q != '0) begin
                    acc_d[8*prev_b +: 8] = mem_rdata;
                end
                if (idx_q == len_q - 1'b1) begin
                    state_d = RESP;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            RESP: begin
                rsp_id_d    = 3'(id_q);
                rsp_rdata_d = rsp_data_c;
                rsp_err_d   = err_q;
                state_d     = IDLE;
            end
`ifdef RNG_STATE_ARB_ZEROIZE_EN
            ZERO: begin
                mem_we   = 1'b1;
                mem_addr = zcnt_q;
                if (zcnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    zcnt_d = zcnt_q - 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // A reset landing mid-transfer must not commit the byte of that cycle.
        if (rst) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_W'(NUM_REQ - 1);
            rsp_id_q     <= '0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
`ifdef RNG_STATE_ARB_ZEROIZE_EN
            zcnt_q       <= '0;
            post_rst_q   <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rsp_id_q     <= rsp_id_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
`ifdef RNG_STATE_ARB_ZEROIZE_EN
            zcnt_q       <= zcnt_d;
            post_rst_q   <= post_rst_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        id_q    <= id_d;
        we_q    <= we_d;
        err_q   <= err_d;
        ofs_q   <= ofs_d;
        len_q   <= len_d;
        idx_q   <= idx_d;
        wdata_q <= wdata_d;
        acc_q   <= acc_d;
    end

    rng_state_mem #(
        .NUM_BYTES (NUM_BYTES),
        .ADDR_W    (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    assign bus.req_ready = rst ? '0 : ready_c;
    assign bus.rsp_valid = !rst && (state_q == RESP);
    assign bus.rsp_id    = rst ? 3'd0  : ((state_q == RESP) ? 3'(id_q) : rsp_id_q);
    assign bus.rsp_rdata = rst ? 64'd0 : ((state_q == RESP) ? rsp_data_c : rsp_rdata_q);
    assign bus.rsp_err   = rst ? 1'b0  : ((state_q == RESP) ? err_q : rsp_err_q);
endmodule
